// File: rtl/bno055_input_pio.sv
// Avalon-MM input PIO for the BNO055 system: synchronizes and debounces an input
// bus, captures selected edges into sticky W1C flags and raises a maskable irq.
module bno055_input_pio #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;

  logic             wr_en_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] rd_field_s;
  logic             unused_wdata_s;

  assign wr_en_s        = chipselect && !write_n;
  assign unused_wdata_s = ^writedata;

  // Per-bit debounce: accept sync2 only after it has differed for N+1 consecutive cycles.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (DEBOUNCE_CYCLES == 0) begin
        stable_d[i] = sync2_q[i];
      end else if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edge selection on the stable value update.
  always_comb begin
    rise_s = stable_d & ~stable_q;
    fall_s = ~stable_d & stable_q;
    if (EDGE_TYPE == 0) begin
      edge_s = rise_s;
    end else if (EDGE_TYPE == 1) begin
      edge_s = fall_s;
    end else begin
      edge_s = rise_s | fall_s;
    end
  end

  // Register writes; a new edge wins over a simultaneous W1C on the same bit.
  always_comb begin
    if (wr_en_s && (address == 2'd2)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end else begin
      irqmask_d = irqmask_q;
    end
    if (wr_en_s && (address == 2'd3)) begin
      w1c_s = writedata[WIDTH-1:0];
    end else begin
      w1c_s = '0;
    end
    edgecap_d = (edgecap_q & ~w1c_s) | edge_s;
  end

  // Read mux; EDGECAP returns the pre-clear value during a W1C.
  always_comb begin
    case (address)
      2'd0:    rd_field_s = stable_q;
      2'd1:    rd_field_s = sync2_q;
      2'd2:    rd_field_s = irqmask_q;
      2'd3:    rd_field_s = edgecap_q;
      default: rd_field_s = '0;
    endcase
    readdata_d                = 32'd0;
    readdata_d[WIDTH-1:0]     = rd_field_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= RESET_VALUE;
      sync2_q    <= RESET_VALUE;
      stable_q   <= RESET_VALUE;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= 32'd0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_bno055_input_pio.sv
// Bench for bno055_input_pio: four instances (rise/fall/any with N=4, any with N=0)
// checked every cycle against a window-based behavioural model plus directed checks.
module tb_bno055_input_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_o [4];
  logic        irq_o [4];

  always #5 clk = ~clk;

  bno055_input_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_VALUE(8'h00)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_o[0]), .irq(irq_o[0]));
  bno055_input_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(8'h00)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_o[1]), .irq(irq_o[1]));
  bno055_input_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_VALUE(8'h00)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_o[2]), .irq(irq_o[2]));
  bno055_input_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .RESET_VALUE(8'h00)) u_nodb (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_o[3]), .irq(irq_o[3]));

  int cfg_n  [4] = '{4, 4, 4, 0};
  int cfg_et [4] = '{0, 1, 2, 2};

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [7:0]  m_s1, m_s2, m_mask;
  logic [7:0]  m_stable [4];
  logic [7:0]  m_cap    [4];
  logic [31:0] m_rd     [4];
  logic [7:0]  hist [$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1   = 8'h00;
    m_s2   = 8'h00;
    m_mask = 8'h00;
    hist.delete();
    for (int i = 0; i < 4; i++) begin
      m_stable[i] = 8'h00;
      m_cap[i]    = 8'h00;
      m_rd[i]     = 32'd0;
    end
  endtask

  // A bit is accepted once the last N+1 synchronized samples all disagree with it.
  task automatic model_edge();
    logic [7:0] ns, ed, w1c;
    bit         all_diff;
    hist.push_front(m_s2);
    if (hist.size() > 5) void'(hist.pop_back());
    w1c = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
    for (int i = 0; i < 4; i++) begin
      case (address)
        2'd0:    m_rd[i] = {24'd0, m_stable[i]};
        2'd1:    m_rd[i] = {24'd0, m_s2};
        2'd2:    m_rd[i] = {24'd0, m_mask};
        default: m_rd[i] = {24'd0, m_cap[i]};
      endcase
      ns = m_stable[i];
      if (hist.size() >= cfg_n[i] + 1) begin
        for (int b = 0; b < 8; b++) begin
          all_diff = 1'b1;
          for (int k = 0; k <= cfg_n[i]; k++)
            if (hist[k][b] == m_stable[i][b]) all_diff = 1'b0;
          if (all_diff) ns[b] = ~m_stable[i][b];
        end
      end
      case (cfg_et[i])
        0:       ed = ns & ~m_stable[i];
        1:       ed = ~ns & m_stable[i];
        default: ed = ns ^ m_stable[i];
      endcase
      m_cap[i]    = (m_cap[i] & ~w1c) | ed;
      m_stable[i] = ns;
    end
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
    m_s2 = m_s1;
    m_s1 = in_port;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("readdata[%0d]", i), rd_o[i], m_rd[i]);
      check($sformatf("irq[%0d]", i), {31'd0, irq_o[i]}, {31'd0, |(m_cap[i] & m_mask)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    int hold_left;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 8'hA5;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_readdata", rd_o[i], 32'd0);
      check("reset_irq", {31'd0, irq_o[i]}, 32'd0);
    end
    hold(2);
    reset_n = 1'b1;

    // Propagation after reset: DATA shows 0xA5 in the read after edge 3+N
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("data_edge%0d", k), rd_o[0], (k >= 8) ? 32'h0000_00A5 : 32'd0);
    end
    rd(2'd3);
    check("cap_rise", rd_o[0], 32'h0000_00A5);
    check("cap_fall", rd_o[1], 32'h0000_0000);
    check("cap_any", rd_o[2], 32'h0000_00A5);
    check("irq_masked", {31'd0, irq_o[0]}, 32'd0);

    // Masked interrupt on bit 0, W1C and write-0 behaviour
    wr(2'd2, 32'h0000_0001);
    in_port = 8'hA4;
    hold(10);
    wr(2'd3, 32'h0000_00FF);
    in_port = 8'hA5;
    hold(6);
    check("irq_before_edge", {31'd0, irq_o[0]}, 32'd0);
    tick();
    check("irq_after_edge", {31'd0, irq_o[0]}, 32'd1);
    wr(2'd3, 32'h0000_0001);
    check("irq_after_w1c", {31'd0, irq_o[0]}, 32'd0);
    wr(2'd3, 32'h0000_0000);
    rd(2'd3);
    check("cap_write0", rd_o[0], 32'd0);

    // Glitch rejection: 4 cycles rejected, 5 cycles accepted
    wr(2'd3, 32'h0000_00FF);
    in_port = 8'hAD;
    hold(4);
    in_port = 8'hA5;
    hold(10);
    rd(2'd0);
    check("glitch4_data", rd_o[0], 32'h0000_00A5);
    rd(2'd3);
    check("glitch4_cap", rd_o[0], 32'd0);
    in_port = 8'hAD;
    hold(5);
    in_port = 8'hA5;
    hold(2);
    rd(2'd0);
    check("pulse5_data", rd_o[0], 32'h0000_00AD);
    rd(2'd3);
    check("pulse5_cap", rd_o[0], 32'h0000_0008);
    hold(10);

    // Edge type selection
    in_port = 8'h00;
    hold(10);
    wr(2'd3, 32'h0000_00FF);
    in_port = 8'hFF;
    hold(10);
    rd(2'd3);
    check("fall_after_rise", rd_o[1], 32'd0);
    check("any_after_rise", rd_o[2], 32'h0000_00FF);
    in_port = 8'h00;
    hold(10);
    rd(2'd3);
    check("fall_after_fall", rd_o[1], 32'h0000_00FF);

    // W1C coinciding with a new edge on bit 2: set wins
    wr(2'd3, 32'h0000_00FF);
    in_port = 8'h04;
    hold(6);
    wr(2'd3, 32'h0000_0004);
    rd(2'd3);
    check("set_wins", rd_o[0], 32'h0000_0004);

    // Reset mid-debounce
    wr(2'd2, 32'h0000_00FF);
    in_port = 8'h0C;
    hold(5);
    check("irq_pre_reset", {31'd0, irq_o[0]}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("async_reset_readdata", rd_o[i], 32'd0);
      check("async_reset_irq", {31'd0, irq_o[i]}, 32'd0);
    end
    hold(2);
    reset_n = 1'b1;
    address = 2'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("rst_data_edge%0d", k), rd_o[0], (k >= 8) ? 32'h0000_000C : 32'd0);
    end

    // Randomized traffic against the model
    hold_left = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold_left == 0) begin
        in_port   = 8'($urandom);
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
